// File: rtl/imem_boot_loader_pkg.sv
// boot_pkg: shared states and constants for the instruction memory boot loader
package boot_pkg;
    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR} boot_state_t;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: host byte stream in, instruction memory write port out
interface imem_boot_loader_if #(parameter int ADDR_W = 8);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    modport master (output in_valid, in_data, input in_ready, imem_we, imem_addr, imem_wdata);
    modport slave  (input in_valid, in_data, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// word_assembler: packs little-endian bytes into 32-bit words
module word_assembler
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strobe,
    input  logic        clear,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word
);
    localparam int LW = $clog2(WORD_BYTES);
    logic [LW-1:0] lane;
    logic [23:0]   shift_q;
    // bytes shift in from the top, so after three the low 24 bits are in place
    assign word_valid = strobe && lane == LW'(WORD_BYTES - 1);
    assign word       = {data, shift_q};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane    <= '0;
            shift_q <= '0;
        end else if (clear) begin
            lane    <= '0;
            shift_q <= '0;
        end else if (strobe) begin
            lane    <= lane + 1'b1;
            shift_q <= {data, shift_q[23:8]};
        end
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a framed, checksummed image into imem and gates core reset
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_boot_loader_if.slave   bus,
    input  logic                reload,
    output logic                cpu_rst_n,
    output logic                load_done,
    output logic                load_error
);
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;
    boot_state_t     state, state_nx;
    logic [7:0]      len_lo, csum;
    logic [15:0]     len, len_in;
    logic [ADDR_W:0] word_cnt;
    logic [16:0]     cnt_nx;
    logic            accept, word_valid, last_word;
    logic [31:0]     word;
    assign bus.in_ready = rst_n && !reload && (state inside {IDLE, LEN_LO, LEN_HI, DATA, CSUM});
    assign accept       = bus.in_valid && bus.in_ready;
    assign len_in       = {bus.in_data, len_lo};
    assign cnt_nx       = 17'(word_cnt) + 17'd1;
    assign last_word    = word_valid && cnt_nx == {1'b0, len};
    assign cpu_rst_n    = state == DONE;
    assign load_done    = state == DONE;
    assign load_error   = state == ERROR;
    word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .strobe     (accept && state == DATA),
        .clear      (state == IDLE),
        .data       (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (reload) state_nx = IDLE;
        else if (accept) begin
            case (state)
                IDLE:    state_nx = (bus.in_data == SYNC_BYTE) ? LEN_LO : IDLE;
                LEN_LO:  state_nx = LEN_HI;
                LEN_HI:  state_nx = ({1'b0, len_in} > DEPTH) ? ERROR : (len_in == '0) ? CSUM : DATA;
                DATA:    state_nx = last_word ? CSUM : DATA;
                CSUM:    state_nx = (bus.in_data == csum) ? DONE : ERROR;
                default: state_nx = state;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo         <= '0;
            len            <= '0;
            csum           <= '0;
            word_cnt       <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
        end else begin
            bus.imem_we <= word_valid;
            if (word_valid) begin
                bus.imem_addr  <= word_cnt[ADDR_W-1:0];
                bus.imem_wdata <= word;
                word_cnt       <= word_cnt + 1'b1;
            end
            if (state == IDLE) begin
                csum     <= '0;
                word_cnt <= '0;
            end
            if (accept && state inside {LEN_LO, LEN_HI, DATA}) csum <= csum ^ bus.in_data;
            if (accept && state == LEN_LO) len_lo <= bus.in_data;
            if (accept && state == LEN_HI) len <= len_in;
        end
    end
endmodule
